// File: rtl/memoria_compartilhada_arbitrada_if.sv
// Request/response bundle for one master port of the shared memory.
// The mascara field exists only when MEM_MASCARA_BYTE_EN is defined.
interface memoria_compartilhada_arbitrada_if #(
  parameter int LARGURA     = 32,
  parameter int LARGURA_END = 32
);
  logic                   req;
  logic                   escMem;
  logic [LARGURA_END-1:0] endereco;
  logic [LARGURA-1:0]     indata;
`ifdef MEM_MASCARA_BYTE_EN
  logic [LARGURA/8-1:0]   mascara;
`endif
  logic                   ack;
  logic [LARGURA-1:0]     output_mem;
  logic                   erro_end;

  modport master (
    output req, escMem, endereco, indata,
`ifdef MEM_MASCARA_BYTE_EN
    output mascara,
`endif
    input  ack, output_mem, erro_end
  );

  modport slave (
    input  req, escMem, endereco, indata,
`ifdef MEM_MASCARA_BYTE_EN
    input  mascara,
`endif
    output ack, output_mem, erro_end
  );
endinterface

// File: rtl/memoria_compartilhada_arbitrada.sv
// Two-master shared data memory: a round-robin arbiter serialises req/ack
// requests from two cores onto one synchronous single-port array.
// Optional feature macro: MEM_MASCARA_BYTE_EN (byte-masked writes).
module memoria_compartilhada_arbitrada #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 512,
  parameter int LARGURA_END  = 32,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  memoria_compartilhada_arbitrada_if.slave porta0,
  memoria_compartilhada_arbitrada_if.slave porta1,
  output logic [LARGURA_CONT-1:0] contador_conflitos
);
  localparam int IDX_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [LARGURA_END:0] LIMITE = (LARGURA_END+1)'(PROFUNDIDADE);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  // Port that won the most recent grant (1 = port 1); steers the next tie.
  logic ultimo;

  logic                   elig0_p0, elig1_p0;
  logic                   grant0_p0, grant1_p0;
  logic                   sel_wr_p0;
  logic [LARGURA_END-1:0] sel_addr_p0;
  logic [LARGURA-1:0]     sel_data_p0;
  logic [IDX_W-1:0]       idx_p0;
  logic                   em_faixa_p0;
  logic                   escreve_p0;
`ifdef MEM_MASCARA_BYTE_EN
  logic [LARGURA/8-1:0]   sel_mask_p0;
`endif

  function automatic logic [LARGURA_CONT-1:0] sat_inc(input logic [LARGURA_CONT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: eligibility, arbitration and request select ----
  // A port in its own ack cycle is not eligible, so a held req becomes a new request only afterwards.
  always_comb begin
    elig0_p0    = porta0.req & ~porta0.ack;
    elig1_p0    = porta1.req & ~porta1.ack;
    grant0_p0   = elig0_p0 & (~elig1_p0 | ultimo);
    grant1_p0   = elig1_p0 & (~elig0_p0 | ~ultimo);
    sel_wr_p0   = grant1_p0 ? porta1.escMem   : porta0.escMem;
    sel_addr_p0 = grant1_p0 ? porta1.endereco : porta0.endereco;
    sel_data_p0 = grant1_p0 ? porta1.indata   : porta0.indata;
`ifdef MEM_MASCARA_BYTE_EN
    sel_mask_p0 = grant1_p0 ? porta1.mascara  : porta0.mascara;
`endif
    idx_p0      = sel_addr_p0[IDX_W-1:0];
    em_faixa_p0 = {1'b0, sel_addr_p0} < LIMITE;
    escreve_p0  = (grant0_p0 | grant1_p0) & sel_wr_p0 & em_faixa_p0;
  end

  // ---- stage p1: array write (contents survive reset; reset only blocks the write) ----
  // Writes the granted in-range word, byte-selectively when masking is built in.
  always_ff @(posedge clock) begin
    if (!reset && escreve_p0) begin
`ifdef MEM_MASCARA_BYTE_EN
      for (int i = 0; i < LARGURA/8; i++)
        if (sel_mask_p0[i]) mem[idx_p0][8*i +: 8] <= sel_data_p0[8*i +: 8];
`else
      mem[idx_p0] <= sel_data_p0;
`endif
    end
  end

  // Registers ack/error pulses, read data, arbitration history and the conflict count.
  always_ff @(posedge clock) begin
    if (reset) begin
      porta0.ack        <= 1'b0;
      porta1.ack        <= 1'b0;
      porta0.erro_end   <= 1'b0;
      porta1.erro_end   <= 1'b0;
      porta0.output_mem <= '0;
      porta1.output_mem <= '0;
      ultimo            <= 1'b1;
      contador_conflitos <= '0;
    end else begin
      porta0.ack      <= grant0_p0;
      porta1.ack      <= grant1_p0;
      porta0.erro_end <= grant0_p0 & ~em_faixa_p0;
      porta1.erro_end <= grant1_p0 & ~em_faixa_p0;
      // read data holds until the next read on the same port; out-of-range reads return 0
      if (grant0_p0 & ~sel_wr_p0)
        porta0.output_mem <= em_faixa_p0 ? mem[idx_p0] : '0;
      if (grant1_p0 & ~sel_wr_p0)
        porta1.output_mem <= em_faixa_p0 ? mem[idx_p0] : '0;
      if (grant0_p0 | grant1_p0)
        ultimo <= grant1_p0;
      if (elig0_p0 & elig1_p0)
        contador_conflitos <= sat_inc(contador_conflitos);
    end
  end
endmodule

// File: tb/tb_memoria_compartilhada_arbitrada.sv
// Bench for memoria_compartilhada_arbitrada: directed scenarios plus random
// traffic, all checked every cycle against a rule-level model of the memory.
module tb_memoria_compartilhada_arbitrada;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memoria_compartilhada_arbitrada_if #(.LARGURA(32), .LARGURA_END(32)) p0 (), p1 ();
  memoria_compartilhada_arbitrada_if #(.LARGURA(32), .LARGURA_END(32)) s0 (), s1 ();
  logic [15:0] conflitos;
  logic [3:0]  conf_s;

  memoria_compartilhada_arbitrada #(.LARGURA(32), .PROFUNDIDADE(512), .LARGURA_END(32)) dut (
    .clock(clk), .reset(rst), .porta0(p0), .porta1(p1), .contador_conflitos(conflitos));

  // narrow-counter instance so saturation is reachable in a short run
  memoria_compartilhada_arbitrada #(.LARGURA(32), .PROFUNDIDADE(16), .LARGURA_END(32),
                                    .LARGURA_CONT(4)) dut_sat (
    .clock(clk), .reset(rst), .porta0(s0), .porta1(s1), .contador_conflitos(conf_s));

  int unsigned passed = 0, total = 0;

  // reference model state
  logic [31:0] mmem [512];
  bit          mknown [512];
  bit          e_ack [2];
  bit          e_err [2];
  logic [31:0] e_out [2];
  bit          e_known [2];
  int          last_g;
  int unsigned m_conf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // One clock edge of the memory described by its access rules.
  task automatic model_update();
    bit el0, el1;
    int g;
    bit wr;
    logic [31:0] a, d;
    logic [3:0] mk;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        e_ack[p] = 0; e_err[p] = 0; e_out[p] = 32'h0; e_known[p] = 1;
      end
      m_conf = 0; last_g = 1;
      return;
    end
    el0 = p0.req && !e_ack[0];
    el1 = p1.req && !e_ack[1];
    for (int p = 0; p < 2; p++) begin e_ack[p] = 0; e_err[p] = 0; end
    if (el0 && el1) begin
      g = (last_g == 0) ? 1 : 0;
      m_conf = (m_conf < 65535) ? m_conf + 1 : 65535;
    end else if (el0) g = 0;
    else if (el1) g = 1;
    else g = -1;
    if (g < 0) return;
    last_g = g;
    e_ack[g] = 1;
    wr = (g == 0) ? p0.escMem : p1.escMem;
    a  = (g == 0) ? p0.endereco : p1.endereco;
    d  = (g == 0) ? p0.indata : p1.indata;
`ifdef MEM_MASCARA_BYTE_EN
    mk = (g == 0) ? p0.mascara : p1.mascara;
`else
    mk = 4'hF;
`endif
    if (a < 512) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) mmem[a[8:0]][8*b +: 8] = d[8*b +: 8];
        mknown[a[8:0]] = mknown[a[8:0]] | (mk == 4'hF);
      end else begin
        e_out[g] = mmem[a[8:0]];
        e_known[g] = mknown[a[8:0]];
      end
    end else begin
      e_err[g] = 1;
      if (!wr) begin e_out[g] = 32'h0; e_known[g] = 1; end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("ack0", 32'(p0.ack), 32'(e_ack[0]));
    chk("ack1", 32'(p1.ack), 32'(e_ack[1]));
    chk("erro_end0", 32'(p0.erro_end), 32'(e_err[0]));
    chk("erro_end1", 32'(p1.erro_end), 32'(e_err[1]));
    chk("contador_conflitos", 32'(conflitos), m_conf);
    if (e_known[0]) chk("output_mem0", p0.output_mem, e_out[0]);
    if (e_known[1]) chk("output_mem1", p1.output_mem, e_out[1]);
  endtask

  task automatic set_req(int p, bit r, bit w, logic [31:0] a, logic [31:0] d);
    if (p == 0) begin
      p0.req = r; p0.escMem = w; p0.endereco = a; p0.indata = d;
`ifdef MEM_MASCARA_BYTE_EN
      p0.mascara = 4'hF;
`endif
    end else begin
      p1.req = r; p1.escMem = w; p1.endereco = a; p1.indata = d;
`ifdef MEM_MASCARA_BYTE_EN
      p1.mascara = 4'hF;
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  bit act [2];

  initial begin
    for (int i = 0; i < 512; i++) mknown[i] = 0;
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    s0.req = 0; s0.escMem = 0; s0.endereco = 0; s0.indata = 0;
    s1.req = 0; s1.escMem = 0; s1.endereco = 0; s1.indata = 0;
`ifdef MEM_MASCARA_BYTE_EN
    s0.mascara = 4'hF; s1.mascara = 4'hF;
`endif
    do_reset();
    chk("rst_ack0", 32'(p0.ack), 0);
    chk("rst_ack1", 32'(p1.ack), 0);
    chk("rst_out0", p0.output_mem, 0);
    chk("rst_out1", p1.output_mem, 0);
    chk("rst_conf", 32'(conflitos), 0);

    // single-port write then read of word 5
    set_req(0, 1, 1, 5, 32'hDEADBEEF); step();
    chk("t1_wr_ack0", 32'(p0.ack), 1);
    set_req(0, 0, 0, 0, 0); step();
    set_req(0, 1, 0, 5, 0); step();
    chk("t1_rd_ack0", 32'(p0.ack), 1);
    chk("t1_rd_data", p0.output_mem, 32'hDEADBEEF);
    chk("t1_rd_err", 32'(p0.erro_end), 0);
    set_req(0, 0, 0, 0, 0); step();

    // simultaneous write/read of word 10 right after reset: port 0 first
    do_reset();
    set_req(0, 1, 1, 10, 32'h1111_1111); set_req(1, 1, 0, 10, 0); step();
    chk("t2_ack0", 32'(p0.ack), 1);
    chk("t2_ack1_wait", 32'(p1.ack), 0);
    chk("t2_conf", 32'(conflitos), 1);
    set_req(0, 0, 0, 0, 0); step();
    chk("t2_ack1", 32'(p1.ack), 1);
    chk("t2_data1", p1.output_mem, 32'h1111_1111);
    set_req(1, 0, 0, 0, 0); step();

    // both ports holding req: acks alternate, only the first cycle is a tie
    set_req(0, 1, 0, 10, 0); set_req(1, 1, 0, 10, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t3_alt_ack0", 32'(p0.ack), 32'(k % 2));
      chk("t3_alt_ack1", 32'(p1.ack), 32'((k + 1) % 2));
    end
    chk("t3_conf", 32'(conflitos), 2);
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); step();

    // out-of-range accesses
    set_req(1, 1, 0, 600, 0); step();
    chk("t4_ack1", 32'(p1.ack), 1);
    chk("t4_err1", 32'(p1.erro_end), 1);
    chk("t4_out1", p1.output_mem, 0);
    set_req(1, 0, 0, 0, 0); step();
    set_req(0, 1, 1, 88, 32'hCAFE0088); step();
    set_req(0, 0, 0, 0, 0); step();
    set_req(1, 1, 1, 600, 32'hFFFFFFFF); step();
    chk("t4_wr_err1", 32'(p1.erro_end), 1);
    set_req(1, 0, 0, 0, 0); step();
    set_req(0, 1, 0, 88, 0); step();
    chk("t4_word88", p0.output_mem, 32'hCAFE0088);
    set_req(0, 0, 0, 0, 0); step();

`ifdef MEM_MASCARA_BYTE_EN
    set_req(0, 1, 1, 3, 32'hAABBCCDD); step();
    set_req(0, 0, 0, 0, 0); step();
    set_req(0, 1, 1, 3, 32'h11223344); p0.mascara = 4'b0101; step();
    set_req(0, 0, 0, 0, 0); step();
    set_req(1, 1, 1, 3, 32'h55555555); p1.mascara = 4'b0000; step();
    set_req(1, 0, 0, 0, 0); step();
    set_req(0, 1, 0, 3, 0); p0.mascara = 4'b0000; step();
    chk("t5_mask_word3", p0.output_mem, 32'hAA22CC44);
    set_req(0, 0, 0, 0, 0); step();
`endif

    // reset in the cycle a write would be granted
    set_req(0, 1, 1, 20, 32'h12345678); step();
    set_req(0, 0, 0, 0, 0); step();
    set_req(0, 1, 0, 20, 0); step();
    set_req(0, 1, 1, 20, 32'h0BADF00D); rst = 1'b1; step();
    chk("t6_rst_ack0", 32'(p0.ack), 0);
    chk("t6_rst_out0", p0.output_mem, 0);
    chk("t6_rst_conf", 32'(conflitos), 0);
    rst = 1'b0; set_req(0, 0, 0, 0, 0); step();
    set_req(0, 1, 0, 20, 0); step();
    chk("t6_word20", p0.output_mem, 32'h12345678);
    set_req(0, 0, 0, 0, 0); step();

    // random traffic from both masters
    act[0] = 0; act[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(act[p] && !e_ack[p])) begin
          if ($urandom_range(0, 99) < 60) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(512, 4095)) : 32'($urandom_range(0, 31));
            act[p] = 1;
            set_req(p, 1, 1'($urandom_range(0, 1)), a, $urandom);
`ifdef MEM_MASCARA_BYTE_EN
            if (p == 0) p0.mascara = 4'($urandom_range(0, 15));
            else        p1.mascara = 4'($urandom_range(0, 15));
`endif
          end else begin
            act[p] = 0;
            set_req(p, 0, 0, 0, 0);
          end
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); step();

    // saturation of the conflict counter on the 4-bit instance
    do_reset();
    chk("sat_rst", 32'(conf_s), 0);
    for (int k = 1; k <= 20; k++) begin
      s0.req = 1; s1.req = 1; step();
      chk("sat_conf", 32'(conf_s), 32'((k < 15) ? k : 15));
      s0.req = 0; step();
      s1.req = 0; step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
